// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-side front end.
// Holds the register-file geometry defaults, the x0 index and the write-request bundle.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 32;
    localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
    localparam int unsigned REG_DEPTH_DEF      = 32;

    // Hard-wired zero register; writes to it are consumed but never reach the file.
    localparam logic [REG_ADDR_WIDTH_DEF-1:0] REG_X0 = '0;

    // One register-file write request.
    typedef struct packed {
        logic                          we;
        logic [REG_ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO buffering coprocessor results.
// Ports: clk, rst (sync, active-high), push/push_data (write side),
//        pop/head (read side, head is first-word-fall-through), full, empty.
// Push is ignored when full, pop is ignored when empty; no full-bypass.
module wb_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the register file: merges pipeline writebacks and
// buffered coprocessor results onto the single write port, and tracks which
// registers still await a coprocessor result.
// Ports: clk, rst (sync, active-high);
//        pipe_we/pipe_rd/pipe_data in, stall_pipe out (pipeline writeback);
//        cop_issue/cop_issue_rd in (marks a destination pending);
//        cop_valid/cop_rd/cop_data in, cop_ready out (coprocessor results);
//        rf_we/rf_rd/rf_data out (registered register-file write port);
//        chk_rs1/chk_rs2 in, rs1_pending/rs2_pending out (decode hazard query).
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned REG_DEPTH      = REG_DEPTH_DEF,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_we,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0]     pipe_data,
    output logic                      stall_pipe,
    input  logic                      cop_issue,
    input  logic [REG_ADDR_WIDTH-1:0] cop_issue_rd,
    input  logic                      cop_valid,
    output logic                      cop_ready,
    input  logic [REG_ADDR_WIDTH-1:0] cop_rd,
    input  logic [DATA_WIDTH-1:0]     cop_data,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]     rf_data,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
    output logic                      rs1_pending,
    output logic                      rs2_pending
);

    localparam int unsigned ENTRY_W  = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [ENTRY_W-1:0]        fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]     head_data;
    logic [STARVE_W-1:0]       starve_cnt;
    logic [STARVE_W-1:0]       starve_nxt;
    logic                      force_head;
    logic                      sel_pipe;
    logic [REG_DEPTH-1:0]      pending;
    logic [REG_DEPTH-1:0]      pending_nxt;
    wr_req_t                   sel_req;
    wr_req_t                   rf_q;

    // Coprocessor result buffer.
    wb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cop_rd, cop_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_rd, head_data} = fifo_head;

    // No full-bypass: a pop this cycle does not open a slot for a push this cycle.
    assign cop_ready = !rst && !fifo_full;
    assign fifo_push = cop_valid && cop_ready;

    // The FIFO head takes the port once the pipeline has won STARVE_LIMIT times in a row.
    assign force_head = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && !fifo_empty;
    assign stall_pipe = force_head && pipe_we;
    assign sel_pipe   = pipe_we && !force_head;
    assign fifo_pop   = !sel_pipe && !fifo_empty;

    // Source selection, starvation tracking and scoreboard update.
    always_comb begin
        sel_req     = '0;
        starve_nxt  = starve_cnt;
        pending_nxt = pending;

        if (sel_pipe) begin
            sel_req.we   = (pipe_rd != REG_ADDR_WIDTH'(REG_X0));
            sel_req.rd   = REG_ADDR_WIDTH_DEF'(pipe_rd);
            sel_req.data = DATA_WIDTH_DEF'(pipe_data);
        end else if (fifo_pop) begin
            sel_req.we   = (head_rd != REG_ADDR_WIDTH'(REG_X0));
            sel_req.rd   = REG_ADDR_WIDTH_DEF'(head_rd);
            sel_req.data = DATA_WIDTH_DEF'(head_data);
            pending_nxt[head_rd] = 1'b0;
        end

        // A non-empty FIFO that is not popped means the pipeline just won.
        if (fifo_empty || fifo_pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end

        // Applied after the clear so a same-index set wins.
        if (cop_issue && (cop_issue_rd != REG_ADDR_WIDTH'(REG_X0))) begin
            pending_nxt[cop_issue_rd] = 1'b1;
        end
    end

    // State and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q       <= '0;
            starve_cnt <= '0;
            pending    <= '0;
        end else begin
            rf_q       <= sel_req;
            starve_cnt <= starve_nxt;
            pending    <= pending_nxt;
        end
    end

    assign rf_we   = rf_q.we;
    assign rf_rd   = REG_ADDR_WIDTH'(rf_q.rd);
    assign rf_data = DATA_WIDTH'(rf_q.data);

    // x0 never waits on anything.
    assign rs1_pending = (chk_rs1 != REG_ADDR_WIDTH'(REG_X0)) && pending[chk_rs1];
    assign rs2_pending = (chk_rs2 != REG_ADDR_WIDTH'(REG_X0)) && pending[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int          NREG = 32;
    localparam int          FD   = 4;
    localparam int          SL   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          stall_pipe;
    logic          cop_issue;
    logic [AW-1:0] cop_issue_rd;
    logic          cop_valid;
    logic          cop_ready;
    logic [AW-1:0] cop_rd;
    logic [DW-1:0] cop_data;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic          rs1_pending;
    logic          rs2_pending;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .stall_pipe   (stall_pipe),
        .cop_issue    (cop_issue),
        .cop_issue_rd (cop_issue_rd),
        .cop_valid    (cop_valid),
        .cop_ready    (cop_ready),
        .cop_rd       (cop_rd),
        .cop_data     (cop_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .rs1_pending  (rs1_pending),
        .rs2_pending  (rs2_pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } res_t;

    res_t          mq[$];
    int            m_starve = 0;
    bit            m_pend[NREG];
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_rd   = '0;
    logic [DW-1:0] m_data = '0;

    function automatic bit m_force();
        return (m_starve == SL) && (mq.size() != 0);
    endfunction

    function automatic bit m_ready();
        return (rst == 1'b0) && (mq.size() < FD);
    endfunction

    function automatic bit m_stall();
        return m_force() && (pipe_we == 1'b1);
    endfunction

    function automatic bit m_pending(input logic [AW-1:0] idx);
        return (idx != '0) && m_pend[idx];
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        res_t          r;
        bit            frc;
        bit            acc;
        bit            sel;
        logic [AW-1:0] srd;
        logic [DW-1:0] sdata;
        frc = m_force();
        acc = m_ready() && (cop_valid == 1'b1);
        if (rst) begin
            mq.delete();
            m_starve = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_we = 1'b0; m_rd = '0; m_data = '0;
            return;
        end
        if (cop_issue && cop_issue_rd != '0 && m_pend[cop_issue_rd]) begin
            miscompares++;
            $display("FAIL illegal_issue rd=%0d already pending", cop_issue_rd);
        end
        sel = 1'b0; srd = '0; sdata = '0;
        if (pipe_we && !frc) begin
            sel = 1'b1; srd = pipe_rd; sdata = pipe_data;
            m_starve = (mq.size() == 0) ? 0 : ((m_starve < SL) ? m_starve + 1 : SL);
        end else if (mq.size() != 0) begin
            r = mq.pop_front();
            sel = 1'b1; srd = r.rd; sdata = r.data;
            m_pend[r.rd] = 1'b0;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        if (cop_issue && cop_issue_rd != '0) m_pend[cop_issue_rd] = 1'b1;
        if (acc) begin
            r.rd = cop_rd; r.data = cop_data;
            mq.push_back(r);
        end
        m_we = sel && (srd != '0); m_rd = srd; m_data = sdata;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
        cop_issue = 1'b0; cop_issue_rd = '0;
        cop_valid = 1'b0; cop_rd = '0; cop_data = '0;
        chk_rs1 = '0; chk_rs2 = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        advance();
        advance();
        vectors++; if (cop_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cop_ready got=%b exp=0", cop_ready); end
        vectors++; if (rf_we !== 1'b0 || rf_rd !== '0 || rf_data !== '0) begin
            miscompares++; $display("FAIL reset_rf got we=%b rd=%0d data=%h exp all zero", rf_we, rf_rd, rf_data); end
        vectors++; if (stall_pipe !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall_pipe); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance();
            vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL idle_rf_we c=%0d got=%b exp=0", c, rf_we); end
            vectors++; if (cop_ready !== 1'b1) begin miscompares++; $display("FAIL idle_cop_ready c=%0d got=%b exp=1", c, cop_ready); end
            vectors++; if (stall_pipe !== 1'b0) begin miscompares++; $display("FAIL idle_stall c=%0d got=%b exp=0", c, stall_pipe); end
        end
        for (int i = 0; i < NREG; i++) begin
            chk_rs1 = AW'(i);
            #1;
            vectors++; if (rs1_pending !== 1'b0) begin miscompares++; $display("FAIL idle_rs1_pending idx=%0d got=%b exp=0", i, rs1_pending); end
            advance();
        end
        chk_rs1 = '0;
    endtask

    task automatic test_pipe_write();
        pipe_we = 1'b1; pipe_rd = AW'(5); pipe_data = 32'hDEAD_BEEF;
        #1;
        vectors++; if (stall_pipe !== 1'b0) begin miscompares++; $display("FAIL pipe_stall got=%b exp=0", stall_pipe); end
        advance();
        pipe_we = 1'b0;
        #1;
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL pipe_rf_we got=%b exp=1", rf_we); end
        vectors++; if (rf_rd !== AW'(5)) begin miscompares++; $display("FAIL pipe_rf_rd got=%0d exp=5", rf_rd); end
        vectors++; if (rf_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL pipe_rf_data got=%h exp=deadbeef", rf_data); end
        pipe_we = 1'b1; pipe_rd = '0; pipe_data = $urandom;
        advance();
        pipe_we = 1'b0;
        #1;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL pipe_x0_we got=%b exp=0", rf_we); end
        advance();
    endtask

    task automatic test_cop_pending();
        cop_issue = 1'b1; cop_issue_rd = AW'(7);
        advance();
        cop_issue = 1'b0;
        chk_rs1 = AW'(7); chk_rs2 = AW'(7);
        cop_valid = 1'b1; cop_rd = AW'(7); cop_data = 32'h0000_1234;
        #1;
        vectors++; if (rs1_pending !== 1'b1) begin miscompares++; $display("FAIL cop_rs1_set got=%b exp=1", rs1_pending); end
        vectors++; if (rs2_pending !== 1'b1) begin miscompares++; $display("FAIL cop_rs2_set got=%b exp=1", rs2_pending); end
        vectors++; if (cop_ready !== 1'b1) begin miscompares++; $display("FAIL cop_ready_accept got=%b exp=1", cop_ready); end
        advance();
        cop_valid = 1'b0;
        #1;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL cop_early_we got=%b exp=0", rf_we); end
        vectors++; if (rs1_pending !== 1'b1) begin miscompares++; $display("FAIL cop_rs1_held got=%b exp=1", rs1_pending); end
        advance();
        #1;
        vectors++; if (rf_we !== 1'b1 || rf_rd !== AW'(7) || rf_data !== 32'h0000_1234) begin
            miscompares++; $display("FAIL cop_write got we=%b rd=%0d data=%h exp we=1 rd=7 data=00001234", rf_we, rf_rd, rf_data); end
        vectors++; if (rs1_pending !== 1'b0) begin miscompares++; $display("FAIL cop_rs1_clear got=%b exp=0", rs1_pending); end
        advance();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL cop_after_we got=%b exp=0", rf_we); end
        drive_idle();
    endtask

    task automatic test_starvation();
        int pi       = 0;
        int pipe_obs = 0;
        int cop_obs  = 0;
        bit stalled;
        for (int k = 0; k < 8; k++) begin
            pipe_we = 1'b1; pipe_rd = AW'(1 + pi % 15); pipe_data = 32'hA000_0000 + DW'(pi);
            cop_valid = (k == 0); cop_rd = AW'(20); cop_data = 32'h0C0F_FEE0;
            #1;
            vectors++; if (stall_pipe !== (k == 4)) begin miscompares++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, stall_pipe, (k == 4)); end
            vectors++; if (rf_we !== m_we || (m_we && (rf_rd !== m_rd || rf_data !== m_data))) begin
                miscompares++; $display("FAIL starve_rf k=%0d got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h", k, rf_we, rf_rd, rf_data, m_we, m_rd, m_data); end
            if (k == 5) begin
                vectors++; if (rf_we !== 1'b1 || rf_rd !== AW'(20) || rf_data !== 32'h0C0F_FEE0) begin
                    miscompares++; $display("FAIL starve_cop_slot got we=%b rd=%0d data=%h exp we=1 rd=20 data=0c0ffee0", rf_we, rf_rd, rf_data); end
            end
            if (rf_we === 1'b1 && rf_rd === AW'(20)) cop_obs++;
            else if (rf_we === 1'b1) pipe_obs++;
            stalled = m_stall();
            advance();
            if (!stalled) pi++;
        end
        drive_idle();
        #1;
        if (rf_we === 1'b1 && rf_rd === AW'(20)) cop_obs++;
        else if (rf_we === 1'b1) pipe_obs++;
        vectors++; if (pipe_obs !== pi) begin miscompares++; $display("FAIL starve_pipe_lost got=%0d exp=%0d", pipe_obs, pi); end
        vectors++; if (cop_obs !== 1) begin miscompares++; $display("FAIL starve_cop_count got=%0d exp=1", cop_obs); end
        advance();
    endtask

    task automatic test_fifo_full();
        int   pi    = 0;
        int   acc_n = 0;
        bit   stalled;
        bit   acc;
        res_t got[$];
        res_t r;
        for (int k = 0; k < 40; k++) begin
            pipe_we = (k < 20); pipe_rd = AW'(1 + pi % 15); pipe_data = 32'hB000_0000 + DW'(pi);
            cop_valid = (acc_n < 5); cop_rd = AW'(20 + acc_n); cop_data = 32'hC000_0000 + DW'(acc_n);
            #1;
            vectors++; if (cop_ready !== m_ready()) begin miscompares++; $display("FAIL full_ready k=%0d got=%b exp=%b", k, cop_ready, m_ready()); end
            if (k == 3 || k == 4 || k == 5) begin
                vectors++; if (cop_ready !== (k != 4)) begin miscompares++; $display("FAIL full_ready_edge k=%0d got=%b exp=%b", k, cop_ready, (k != 4)); end
            end
            vectors++; if (rf_we !== m_we || (m_we && (rf_rd !== m_rd || rf_data !== m_data))) begin
                miscompares++; $display("FAIL full_rf k=%0d got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h", k, rf_we, rf_rd, rf_data, m_we, m_rd, m_data); end
            if (rf_we === 1'b1 && rf_rd >= AW'(20)) begin
                r.rd = rf_rd; r.data = rf_data; got.push_back(r);
            end
            stalled = m_stall();
            acc     = (cop_valid == 1'b1) && m_ready();
            advance();
            if (acc) acc_n++;
            if (pipe_we && !stalled) pi++;
        end
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL full_cop_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            vectors++; if (got[i].rd !== AW'(20 + i) || got[i].data !== 32'hC000_0000 + DW'(i)) begin
                miscompares++; $display("FAIL full_order idx=%0d got rd=%0d data=%h exp rd=%0d data=%h", i, got[i].rd, got[i].data, 20 + i, 32'hC000_0000 + DW'(i)); end
        end
        drive_idle();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            cop_issue = 1'b1; cop_issue_rd = AW'(9 + i);
            advance();
        end
        cop_issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_rd = AW'(1 + i); pipe_data = $urandom;
            cop_valid = 1'b1; cop_rd = AW'(9 + i); cop_data = 32'hD000_0000 + DW'(i);
            #1;
            vectors++; if (cop_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_push_ready i=%0d got=%b exp=1", i, cop_ready); end
            advance();
        end
        cop_valid = 1'b0;
        chk_rs1 = AW'(9); chk_rs2 = AW'(11);
        #1;
        vectors++; if (rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin
            miscompares++; $display("FAIL mrst_pre_pending got rs1=%b rs2=%b exp 1 1", rs1_pending, rs2_pending); end
        rst = 1'b1; pipe_we = 1'b0;
        advance();
        chk_rs1 = AW'(10);
        #1;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL mrst_rf_we got=%b exp=0", rf_we); end
        vectors++; if (cop_ready !== 1'b0) begin miscompares++; $display("FAIL mrst_cop_ready got=%b exp=0", cop_ready); end
        vectors++; if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
            miscompares++; $display("FAIL mrst_pending got rs1=%b rs2=%b exp 0 0", rs1_pending, rs2_pending); end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk_rs1 = AW'(9 + c % 3);
            advance();
            vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL mrst_leak c=%0d got we=%b rd=%0d", c, rf_we, rf_rd); end
            vectors++; if (rs1_pending !== 1'b0) begin miscompares++; $display("FAIL mrst_pend_stays c=%0d got=%b exp=0", c, rs1_pending); end
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [AW-1:0] issued[$];
        logic [AW-1:0] r;
        bit            stalled = 1'b0;
        bit            acc;
        int            prob;
        drive_idle();
        for (int c = 0; c < 600; c++) begin
            prob = (c / 150 == 0) ? 30 : (c / 150 == 1) ? 95 : (c / 150 == 2) ? 60 : 85;
            if (!stalled) begin
                pipe_we   = ($urandom_range(0, 99) < prob);
                pipe_rd   = AW'($urandom);
                pipe_data = $urandom;
            end
            if (!cop_valid && issued.size() != 0 && $urandom_range(0, 2) == 0) begin
                cop_valid = 1'b1; cop_rd = issued[0]; cop_data = $urandom;
            end
            cop_issue = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                r = AW'($urandom);
                if (r == '0 || !m_pend[r]) begin
                    cop_issue = 1'b1; cop_issue_rd = r;
                end
            end
            chk_rs1 = AW'($urandom);
            chk_rs2 = AW'($urandom);
            #1;
            vectors++; if (rf_we !== m_we) begin miscompares++; $display("FAIL rand_rf_we c=%0d got=%b exp=%b", c, rf_we, m_we); end
            if (m_we) begin
                vectors++; if (rf_rd !== m_rd || rf_data !== m_data) begin
                    miscompares++; $display("FAIL rand_rf_payload c=%0d got rd=%0d data=%h exp rd=%0d data=%h", c, rf_rd, rf_data, m_rd, m_data); end
            end
            vectors++; if (cop_ready !== m_ready()) begin miscompares++; $display("FAIL rand_cop_ready c=%0d got=%b exp=%b", c, cop_ready, m_ready()); end
            vectors++; if (stall_pipe !== m_stall()) begin miscompares++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall_pipe, m_stall()); end
            vectors++; if (rs1_pending !== m_pending(chk_rs1)) begin miscompares++; $display("FAIL rand_rs1 c=%0d idx=%0d got=%b exp=%b", c, chk_rs1, rs1_pending, m_pending(chk_rs1)); end
            vectors++; if (rs2_pending !== m_pending(chk_rs2)) begin miscompares++; $display("FAIL rand_rs2 c=%0d idx=%0d got=%b exp=%b", c, chk_rs2, rs2_pending, m_pending(chk_rs2)); end
            stalled = m_stall();
            acc     = (cop_valid == 1'b1) && m_ready();
            advance();
            if (cop_issue) issued.push_back(cop_issue_rd);
            if (acc) begin
                cop_valid = 1'b0;
                void'(issued.pop_front());
            end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_pipe_write();
        test_cop_pending();
        test_starvation();
        test_fifo_full();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
